alu_shift_seq: RTL and testbench

Iterative multi-cycle shifter for the CPU's ALU: arithmetic right, logical right and logical left shift. It shifts the operand one bit per clock and holds the result stable on a registered bus. That bus drives the SRA/shift input (select code 3'b111) of the per-bit ALU result multiplexers. The sequencer raises `busy` while shifting and pulses `done` when the result is valid.

---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu_shift_seq_if.sv | 30 +++
 rtl/alu_shift_seq_shift_step.sv | 31 +++
 rtl/alu_shift_seq.sv | 112 +++++++++++
 tb/tb_alu_shift_seq.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Purpose  : Shared ALU constants: shift op encodings, shifter FSM states and
//            the downstream result-mux select code for the shifter output.
// Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // Shift kind encodings carried on the op field
    localparam logic [1:0] SH_SLL = 2'b00;
    localparam logic [1:0] SH_SRL = 2'b01;
    localparam logic [1:0] SH_RSV = 2'b10;  // reserved: passes the operand through
    localparam logic [1:0] SH_SRA = 2'b11;

    // Per-bit ALU result mux code that selects the shifter result bus
    localparam logic [2:0] SEL_SRA = 3'b111;

    // Shifter sequencer states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } shift_state_e;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_shift_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_shift_seq_if
// Purpose  : Request/result bundle between the ALU control and the iterative
//            shifter. master = requester, slave = shifter.
// Revision : 1.0 - initial release
// ============================================================================
interface alu_shift_seq_if #(
    parameter int WIDTH = 16,
    parameter int SHW   = 4
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] result;
    logic             busy;
    logic             done;

    modport master (
        output start, op, a, shamt,
        input  result, busy, done
    );

    modport slave (
        input  start, op, a, shamt,
        output result, busy, done
    );
endinterface : alu_shift_seq_if
`default_nettype wire

// File: rtl/alu_shift_seq_shift_step.sv
`default_nettype none
// ============================================================================
// Module   : shift_step
// Purpose  : One-bit shift of the shifter working register. Purely
//            combinational; the fill bit is the captured sign for SRA.
// Revision : 1.0 - initial release
// ============================================================================
import alu_pkg::*;

module shift_step #(
    parameter int WIDTH = 16
) (
    input  wire logic [1:0]       i_op,
    input  wire logic             i_fill,
    input  wire logic [WIDTH-1:0] i_value,
    output logic      [WIDTH-1:0] o_value
);

    // Select the single-bit shift direction and fill source from the op
    always_comb begin
        o_value = i_value;
        case (i_op)
            SH_SLL:  o_value = {i_value[WIDTH-2:0], 1'b0};
            SH_SRL:  o_value = {1'b0, i_value[WIDTH-1:1]};
            SH_SRA:  o_value = {i_fill, i_value[WIDTH-1:1]};
            default: o_value = i_value;  // reserved op never shifts
        endcase
    end

endmodule : shift_step
`default_nettype wire

// File: rtl/alu_shift_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_shift_seq
// Purpose  : Iterative shifter (SLL/SRL/SRA), one bit per clock. The result
//            bus only updates on entry to DONE so the downstream result muxes
//            (select SEL_SRA) never see intermediate shift values.
// Revision : 1.0 - initial release
// ============================================================================
import alu_pkg::*;

module alu_shift_seq #(
    parameter int WIDTH = 16,
    parameter int SHW   = 4
) (
    input  wire logic      clk,
    input  wire logic      rst_n,
    alu_shift_seq_if.slave bus
);

    localparam logic [1:0] S_IDLE  = 2'(IDLE);
    localparam logic [1:0] S_SHIFT = 2'(SHIFT);
    localparam logic [1:0] S_DONE  = 2'(DONE);

    logic [1:0]       state_q,  state_d;
    logic [WIDTH-1:0] work_q,   work_d;
    logic [SHW-1:0]   cnt_q,    cnt_d;
    logic [1:0]       op_q,     op_d;
    logic             sign_q,   sign_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             busy_q,   busy_d;
    logic             done_q,   done_d;

    logic [WIDTH-1:0] w_step;

    shift_step #(
        .WIDTH (WIDTH)
    ) u_shift_step (
        .i_op    (op_q),
        .i_fill  (sign_q),
        .i_value (work_q),
        .o_value (w_step)
    );

    // Next-state, capture and shift sequencing
    always_comb begin
        state_d  = state_q;
        work_d   = work_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        sign_d   = sign_q;
        result_d = result_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    work_d  = bus.a;
                    // Reserved op loads a zero count so the operand passes straight through
                    cnt_d   = (bus.op == SH_RSV) ? '0 : bus.shamt;
                    op_d    = bus.op;
                    sign_d  = bus.a[WIDTH-1];
                    state_d = S_SHIFT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SHIFT: begin
                // start is deliberately not looked at here: no queueing
                if (cnt_q != '0) begin
                    work_d = w_step;
                    cnt_d  = cnt_q - SHW'(1);
                end else begin
                    result_d = work_q;
                    state_d  = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Status flags are registered from the next state so outputs are pure flops
        busy_d = (state_d == S_SHIFT);
        done_d = (state_d == S_DONE);
    end

    // State and datapath registers, cleared asynchronously by rst_n
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            work_q   <= '0;
            cnt_q    <= '0;
            op_q     <= SH_SLL;
            sign_q   <= 1'b0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            work_q   <= work_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            sign_q   <= sign_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.result = result_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;

endmodule : alu_shift_seq
`default_nettype wire

// File: tb/tb_alu_shift_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_shift_seq
// Purpose  : Scoreboard bench for alu_shift_seq: directed cases plus random
//            requests checked against a behavioural shift model, including
//            latency, busy length, done uniqueness and async reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_shift_seq;

    localparam int WIDTH = 16;
    localparam int SHW   = 4;

    typedef struct {
        logic [WIDTH-1:0] res;
        int               acc;
        int               lat;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_tests;
    int   n_fail;
    int   n_accept;
    int   n_done;
    int   busy_cnt;
    exp_t sb[$];

    alu_shift_seq_if #(.WIDTH(WIDTH), .SHW(SHW)) bus ();

    alu_shift_seq #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [WIDTH-1:0] ref_shift(input logic [1:0] op,
                                                   input logic [WIDTH-1:0] a,
                                                   input int sh);
        logic signed [WIDTH-1:0] s;
        s = a;
        case (op)
            2'b00:   return a << sh;
            2'b01:   return a >> sh;
            2'b11:   return s >>> sh;
            default: return a;
        endcase
    endfunction

    // Called at a negedge where the DUT is in IDLE or DONE; returns 1ns after the accepting edge
    task automatic send(input logic [1:0] op, input logic [WIDTH-1:0] a, input int sh);
        exp_t e;
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.shamt = SHW'(sh);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        e.res = ref_shift(op, a, sh);
        e.acc = cyc;
        e.lat = (op == 2'b10) ? 1 : sh + 1;
        sb.push_back(e);
        n_accept++;
    endtask

    // Returns at the negedge of the done cycle
    task automatic wait_done(input int bound);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < bound && !seen; i++) begin
            @(negedge clk);
            if (bus.done) seen = 1'b1;
        end
        if (!seen) check("done_timeout", 32'd0, 32'd1);
    endtask

    // Output monitor: compares each completion with the scoreboard head
    always @(negedge clk) begin
        if (!rst_n) begin
            busy_cnt = 0;
        end else begin
            if (bus.busy && bus.done) check("busy_done_overlap", 32'd1, 32'd0);
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                n_done++;
                if (sb.size() == 0) begin
                    check("spurious_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("result", 32'(bus.result), 32'(e.res));
                    check("latency", 32'(cyc - e.acc), 32'(e.lat));
                    check("busy_cycles", 32'(busy_cnt), 32'(e.lat));
                end
                busy_cnt = 0;
            end
        end
    end

    initial begin
        cyc = 0; n_tests = 0; n_fail = 0; n_accept = 0; n_done = 0; busy_cnt = 0;
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.a     = '0;
        bus.shamt = '0;
        rst_n     = 1'b1;
        #2 rst_n  = 1'b0;
        #1;
        check("rst_result", 32'(bus.result), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;

        // Directed single requests
        @(negedge clk); send(2'b11, 16'h8000, 3);  wait_done(40);
        @(negedge clk); send(2'b01, 16'h8000, 3);  wait_done(40);
        @(negedge clk); send(2'b00, 16'h0001, 15); wait_done(40);
        @(negedge clk); send(2'b11, 16'h1234, 0);  wait_done(40);
        @(negedge clk); send(2'b10, 16'hABCD, 5);  wait_done(40);

        // start pulsed mid-SHIFT with a different operand must be ignored
        @(negedge clk); send(2'b11, 16'h8000, 7);
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'b00; bus.a = 16'h0001; bus.shamt = 4'd1;
        @(posedge clk); #1 bus.start = 1'b0;
        wait_done(40);

        // Back-to-back: second start in the done cycle
        @(negedge clk); send(2'b01, 16'hF0F0, 2);  wait_done(40);
        send(2'b00, 16'h0003, 4);                  wait_done(40);

        // Async reset in the second SHIFT cycle of SRA shamt=7
        @(negedge clk); send(2'b11, 16'h8001, 7);
        @(posedge clk);
        #2 rst_n = 1'b0;
        n_accept -= sb.size();
        sb.delete();
        #1;
        check("midrst_result", 32'(bus.result), 32'd0);
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_done", 32'(bus.done), 32'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk); send(2'b00, 16'h00FF, 4);  wait_done(40);
        check("sll_after_rst", 32'(bus.result), 32'h0FF0);

        // Random requests, mixing back-to-back and idle gaps
        @(negedge clk);
        for (int k = 0; k < 1000; k++) begin
            int gap;
            send(2'($urandom_range(0, 3)), 16'($urandom), int'($urandom_range(0, 15)));
            wait_done(40);
            gap = int'($urandom_range(0, 2));
            repeat (gap) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        check("done_count", 32'(n_done), 32'(n_accept));
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_alu_shift_seq
`default_nettype wire
